xswitch_port_rx: RTL and testbench



---
 rtl/xswitch_pkg.sv | 13 +
 rtl/xswitch_port_rx_if.sv | 26 ++
 rtl/xswitch_rx_fifo.sv | 52 +++++
 rtl/xswitch_port_rx.sv | 65 ++++++
 tb/tb_xswitch_port_rx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/xswitch_pkg.sv
// rtl/xswitch_pkg.sv - shared xswitch constants and receive word type
package xswitch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [DATA_W-1:0] data;
    } rx_word_t;

endpackage

// File: rtl/xswitch_port_rx_if.sv
// rtl/xswitch_port_rx_if.sv - switch-side and consumer-side handshake bundle of one receive port
interface xswitch_port_rx_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);

    logic              valid_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              data_rd;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_src;
    logic              m_ready;

    modport slave (
        input  valid_out, addr_out, data_out, m_ready,
        output data_rd, m_valid, m_data, m_src
    );

    modport master (
        output valid_out, addr_out, data_out, m_ready,
        input  data_rd, m_valid, m_data, m_src
    );

endinterface

// File: rtl/xswitch_rx_fifo.sv
// rtl/xswitch_rx_fifo.sv - first-word-fall-through FIFO with occupancy count
module xswitch_rx_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = xswitch_pkg::rx_word_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  T                         wdata,
    input  logic                     pop,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/xswitch_port_rx.sv
// rtl/xswitch_port_rx.sv - xswitch output-port receive stage: acknowledge, buffer, count, error flag
module xswitch_port_rx #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                                         clk,
    input  logic                                         reset,
    xswitch_port_rx_if.slave                             bus,
    output logic [$clog2(DEPTH):0]                       count,
    output logic                                         full,
    output logic [xswitch_pkg::NUM_PORTS-1:0][CNT_W-1:0] src_cnt,
    output logic                                         proto_err
);

    import xswitch_pkg::*;

    logic     accept;
    logic     pop;
    logic     empty;
    logic     ack;
    rx_word_t wword;
    rx_word_t rword;

    // The acknowledge cycle masks valid_out so the word still shown is not taken twice.
    assign accept = bus.valid_out && !ack && !full;
    assign pop    = bus.m_valid && bus.m_ready;
    assign wword  = '{src: bus.addr_out, data: bus.data_out};

    xswitch_rx_fifo #(
        .DEPTH (DEPTH),
        .T     (rx_word_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (wword),
        .pop   (pop),
        .rdata (rword),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ack       <= 1'b0;
            src_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            ack <= accept;
            if (accept && (src_cnt[bus.addr_out] != '1))
                src_cnt[bus.addr_out] <= src_cnt[bus.addr_out] + CNT_W'(1);
            if (ack && !bus.valid_out)
                proto_err <= 1'b1;
        end
    end

    assign bus.data_rd = ack;
    assign bus.m_valid = !empty;
    assign bus.m_data  = rword.data;
    assign bus.m_src   = rword.src;

endmodule

// File: tb/tb_xswitch_port_rx.sv
// tb/tb_xswitch_port_rx.sv - scoreboard bench for xswitch_port_rx
module tb_xswitch_port_rx;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       count;
    logic             full;
    logic [3:0][15:0] src_cnt;
    logic             proto_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] sb [$];
    int exp_cnt [4];

    xswitch_port_rx_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    xswitch_port_rx #(
        .DATA_W (8),
        .ADDR_W (2),
        .DEPTH  (8),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .count     (count),
        .full      (full),
        .src_cnt   (src_cnt),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consumer-side monitor: a head shown with m_ready high is popped on the next edge.
    always @(negedge clk) begin
        if (!reset && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", {22'd0, bus.m_src, bus.m_data}, 32'h3ff);
            end else begin
                chk("pop_word", {22'd0, bus.m_src, bus.m_data}, {22'd0, sb[0]});
                void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic [7:0] d, input bit hold_ack);
        bit got = 0;
        bus.valid_out = 1'b1;
        bus.addr_out  = s;
        bus.data_out  = d;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (bus.data_rd)
                got = 1;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        if (got) begin
            sb.push_back({s, d});
            exp_cnt[s]++;
        end
        if (!hold_ack) begin
            bus.valid_out = 1'b0;
        end else begin
            step();
            chk("ack_one_cycle", {31'd0, bus.data_rd}, 32'd0);
            bus.valid_out = 1'b0;
        end
    endtask

    task automatic drain();
        bit done = 0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            if (count == 0)
                done = 1;
        end
        bus.m_ready = 1'b0;
        chk("drain_done", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_src_cnts(input string name);
        for (int p = 0; p < 4; p++)
            chk(name, {16'd0, src_cnt[p]}, exp_cnt[p]);
    endtask

    initial begin
        bus.valid_out = 1'b0;
        bus.addr_out  = '0;
        bus.data_out  = '0;
        bus.m_ready   = 1'b0;
        for (int p = 0; p < 4; p++) exp_cnt[p] = 0;
        step();
        step();
        reset = 1'b0;

        chk("rst_data_rd", {31'd0, bus.data_rd}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        chk_src_cnts("rst_src_cnt");

        // Single word
        send(2'd2, 8'hA5, 1);
        chk("single_m_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("single_m_src", {30'd0, bus.m_src}, 32'd2);
        chk("single_m_data", {24'd0, bus.m_data}, 32'hA5);
        chk("single_src_cnt2", {16'd0, src_cnt[2]}, 32'd1);
        chk("single_count", {28'd0, count}, 32'd1);
        drain();

        // Fill to full, ninth word held off until a pop frees space
        for (int i = 0; i < 8; i++)
            send(2'd1, 8'(i), 1);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {28'd0, count}, 32'd8);
        bus.valid_out = 1'b1;
        bus.addr_out  = 2'd1;
        bus.data_out  = 8'h08;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_ack", {31'd0, bus.data_rd}, 32'd0);
        end
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("full_pop_no_ack", {31'd0, bus.data_rd}, 32'd0);
        chk("full_pop_count", {28'd0, count}, 32'd7);
        step();
        chk("after_pop_ack", {31'd0, bus.data_rd}, 32'd1);
        sb.push_back({2'd1, 8'h08});
        exp_cnt[1]++;
        step();
        chk("after_pop_ack_low", {31'd0, bus.data_rd}, 32'd0);
        bus.valid_out = 1'b0;
        chk("after_pop_count", {28'd0, count}, 32'd8);
        chk("fill_src_cnt1", {16'd0, src_cnt[1]}, 32'd9);
        drain();

        // Wrap-around with interleaved pops
        for (int i = 0; i < 20; i++) begin
            bus.m_ready = (i % 3) != 0;
            send(2'(i % 4), 8'(8'h10 + i), 1);
            chk("wrap_count_bound", {31'd0, count <= 4'd8}, 32'd1);
        end
        bus.m_ready = 1'b0;
        drain();
        chk_src_cnts("wrap_src_cnt");

        // Simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++)
            send(2'd3, 8'(8'h30 + i), 1);
        chk("sim_pre_count", {28'd0, count}, 32'd3);
        bus.valid_out = 1'b1;
        bus.addr_out  = 2'd3;
        bus.data_out  = 8'h33;
        bus.m_ready   = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("sim_count", {28'd0, count}, 32'd3);
        chk("sim_ack", {31'd0, bus.data_rd}, 32'd1);
        sb.push_back({2'd3, 8'h33});
        exp_cnt[3]++;
        step();
        chk("sim_ack_low", {31'd0, bus.data_rd}, 32'd0);
        bus.valid_out = 1'b0;
        drain();

        // Source withdraws during the acknowledge cycle
        send(2'd0, 8'h5A, 0);
        step();
        chk("perr_set", {31'd0, proto_err}, 32'd1);
        chk("perr_ack_low", {31'd0, bus.data_rd}, 32'd0);
        chk("perr_count", {28'd0, count}, 32'd1);
        step();
        step();
        chk("perr_sticky", {31'd0, proto_err}, 32'd1);
        chk("perr_no_recapture", {28'd0, count}, 32'd1);
        chk_src_cnts("perr_src_cnt");
        drain();

        // Reset with count 5 and an acknowledge pending
        for (int i = 0; i < 4; i++)
            send(2'd2, 8'(8'h40 + i), 1);
        send(2'd2, 8'h44, 0);
        bus.valid_out = 1'b1;
        chk("mid_pre_count", {28'd0, count}, 32'd5);
        chk("mid_pre_ack", {31'd0, bus.data_rd}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.valid_out = 1'b0;
        sb.delete();
        for (int p = 0; p < 4; p++) exp_cnt[p] = 0;
        chk("mid_rst_count", {28'd0, count}, 32'd0);
        chk("mid_rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("mid_rst_data_rd", {31'd0, bus.data_rd}, 32'd0);
        chk("mid_rst_proto_err", {31'd0, proto_err}, 32'd0);
        chk_src_cnts("mid_rst_src_cnt");

        step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
